alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/opcodes_pkg.sv | 34 +++
 rtl/alu_arb_pick.sv | 47 ++++
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opcodes_pkg.sv
// -----------------------------------------------------------------------------
// opcodes
// Shared types for the ALU arbiter slice: the register and instruction types
// handed to the ALU, the arbiter state encoding, and the upper bound on the
// number of requesters sharing one ALU.
// -----------------------------------------------------------------------------
package opcodes;

   localparam int ALU_ARB_MAX_REQ = 4;
   localparam int XLEN            = 32;

   typedef logic [XLEN-1:0] register_t;

   // ALU operation selector. AUIPC adds op1 (already-shifted upper
   // immediate) to the PC. LUI passes op1 through.
   typedef enum logic [3:0] {
      M_ADD   = 4'd0,
      M_SUB   = 4'd1,
      M_AND   = 4'd2,
      M_OR    = 4'd3,
      M_XOR   = 4'd4,
      M_SLL   = 4'd5,
      M_AUIPC = 4'd6,
      M_LUI   = 4'd7
   } instruction_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } alu_arb_state_t;

endpackage

// File: rtl/alu_arb_pick.sv
// -----------------------------------------------------------------------------
// alu_arb_pick
// Combinational requester selection. It scans the valid vector starting at
// 'pointer' and wrapping modulo NUM_REQ. It returns a one-hot grant and the
// index of the winner. A pointer tied to zero gives fixed lowest-index priority.
//
// Ports:
//   valid   [NUM_REQ-1:0]  requesters asking for the ALU
//   pointer [ID_W-1:0]     index the search starts from
//   grant   [NUM_REQ-1:0]  one-hot winner, all-zero when nothing is valid
//   id      [ID_W-1:0]     index of the winner, zero when nothing is valid
// -----------------------------------------------------------------------------
module alu_arb_pick
   import opcodes::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
)
(
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    pointer,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    id
);

   logic            found;
   logic [ID_W-1:0] idx;

   // Walk the requesters in priority order: pointer, pointer+1, ... wrapping
   // around. Take the first valid one. Only the valid vector and the pointer
   // feed this search, so the payload never influences who wins.
   always_comb begin
      grant = '0;
      id    = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((int'(pointer) + k) % NUM_REQ);
         if (!found && valid[idx]) begin
            grant = NUM_REQ'(1) << idx;
            id    = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one externally instantiated, registered-result ALU between NUM_REQ
// requesters. Only one operation is outstanding at a time. The sequence is
// IDLE (accept), ISSUE (alu_enable pulse), WAIT (capture result), then
// RESP (hold the response until rsp_ready).
//
// Configuration macro ALU_ARB_RR_EN:
//   defined   -> round-robin. A pointer moves to winner+1 on every accept.
//   undefined -> fixed priority. The lowest index wins and there is no pointer
//                register.
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   req_valid/req_ready            per-requester handshake
//   req_instr/op1/op2/pc           per-requester payload
//   alu_rst                        active-high ALU reset (~rst)
//   alu_enable                     one-cycle evaluate strobe
//   alu_instr/op1/op2/pc           captured operation, held ISSUE..RESP
//   alu_result                     ALU result, valid the cycle after enable
//   rsp_valid/rsp_ready            response handshake
//   rsp_id, rsp_result             owner and value of the response
// -----------------------------------------------------------------------------
module alu_arbiter
   import opcodes::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   input  instruction_t       req_instr [NUM_REQ],
   input  register_t          req_op1   [NUM_REQ],
   input  register_t          req_op2   [NUM_REQ],
   input  register_t          req_pc    [NUM_REQ],
   output logic               alu_rst,
   output logic               alu_enable,
   output instruction_t       alu_instr,
   output register_t          alu_op1,
   output register_t          alu_op2,
   output register_t          alu_pc,
   input  register_t          alu_result,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output register_t          rsp_result
);

   alu_arb_state_t     state;
   logic [ID_W-1:0]    pointer;
   logic [ID_W-1:0]    pick_id;
   logic [ID_W-1:0]    win_id;
   logic [NUM_REQ-1:0] grant;
   logic               accept;

`ifdef ALU_ARB_RR_EN
   // Round-robin pointer. After each accept the requester just served moves
   // to the lowest priority. Reset returns the search start to requester 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pointer <= '0;
      end else if (accept) begin
         pointer <= ID_W'((int'(pick_id) + 1) % NUM_REQ);
      end
   end
`else
   assign pointer = '0;
`endif

   alu_arb_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .valid   (req_valid),
      .pointer (pointer),
      .grant   (grant),
      .id      (pick_id)
   );

   // Grants are offered only in IDLE and only while out of reset. Gating on
   // rst stops a request from being taken in the same cycle that reset is
   // forcing the FSM back to IDLE.
   assign req_ready  = (rst && state == IDLE) ? grant : '0;
   assign accept     = |(req_valid & req_ready);
   assign alu_rst    = ~rst;
   assign alu_enable = (state == ISSUE);
   assign rsp_valid  = (state == RESP);

   // Operation sequencer. Each state after IDLE lasts exactly one cycle,
   // except RESP, which waits for the consumer. Reset drops any
   // in-flight operation without producing a response.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (accept)    state <= ISSUE;
            ISSUE:                  state <= WAIT;
            WAIT:                   state <= RESP;
            RESP:    if (rsp_ready) state <= IDLE;
            default:                state <= IDLE;
         endcase
      end
   end

   // Payload and response registers. The operation is latched at accept, so
   // requesters may change their payload right afterwards. The ALU result
   // is latched in WAIT, which is the cycle after the enable pulse. That is
   // when the registered ALU output is valid. All of these hold until they
   // are overwritten by the next operation or cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         alu_instr  <= M_ADD;
         alu_op1    <= '0;
         alu_op2    <= '0;
         alu_pc     <= '0;
         win_id     <= '0;
         rsp_id     <= '0;
         rsp_result <= '0;
      end else begin
         if (accept) begin
            alu_instr <= req_instr[pick_id];
            alu_op1   <= req_op1[pick_id];
            alu_op2   <= req_op2[pick_id];
            alu_pc    <= req_pc[pick_id];
            win_id    <= pick_id;
         end
         if (state == WAIT) begin
            rsp_result <= alu_result;
            rsp_id     <= win_id;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter with NUM_REQ=2. It contains a
// registered-result ALU model, because the real ALU lives outside the
// arbiter. It runs:
//   - table-driven single operations,
//   - hand-written sequences for the response stall, reset during WAIT and
//     back-to-back arbitration,
//   - a randomized run checked against a transaction-level reference.
// Build with +define+ALU_ARB_RR_EN to check the round-robin variant.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
   import opcodes::*;

   localparam int NUM_REQ = 2;
   localparam int ID_W    = 1;

   logic               clk;
   logic               rst;
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_ready;
   instruction_t       req_instr [NUM_REQ];
   register_t          req_op1   [NUM_REQ];
   register_t          req_op2   [NUM_REQ];
   register_t          req_pc    [NUM_REQ];
   logic               alu_rst;
   logic               alu_enable;
   instruction_t       alu_instr;
   register_t          alu_op1;
   register_t          alu_op2;
   register_t          alu_pc;
   register_t          alu_result;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [ID_W-1:0]    rsp_id;
   register_t          rsp_result;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      int unsigned  id;
      instruction_t instr;
      register_t    op1;
      register_t    op2;
      register_t    pc;
      register_t    result;
   } vec_t;

   vec_t vecs [6];

   alu_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_instr  (req_instr),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .req_pc     (req_pc),
      .alu_rst    (alu_rst),
      .alu_enable (alu_enable),
      .alu_instr  (alu_instr),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_pc     (alu_pc),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic meaning of each opcode, used both by the ALU model and by
   // the reference model
   function automatic register_t aluRef(input instruction_t i, input register_t a,
                                        input register_t b, input register_t pc);
      case (i)
         M_ADD:   return a + b;
         M_SUB:   return a - b;
         M_AND:   return a & b;
         M_OR:    return a | b;
         M_XOR:   return a ^ b;
         M_SLL:   return a << b[4:0];
         M_AUIPC: return pc + a;
         M_LUI:   return a;
         default: return '0;
      endcase
   endfunction

   // External ALU: its result register updates on the enable pulse, so the
   // value is visible the following cycle
   always_ff @(posedge clk) begin
      if (alu_rst) alu_result <= '0;
      else if (alu_enable) alu_result <= aluRef(alu_instr, alu_op1, alu_op2, alu_pc);
   end

   // Requester that the arbitration rules pick from a valid set and a start
   // index. Returns -1 when nobody asks.
   function automatic int pickRef(input logic [NUM_REQ-1:0] v, input int start);
      for (int k = 0; k < NUM_REQ; k++)
         if (v[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic scramblePayload();
      for (int r = 0; r < NUM_REQ; r++) begin
         req_instr[r] = instruction_t'(4'($urandom_range(0, 7)));
         req_op1[r]   = $urandom;
         req_op2[r]   = $urandom;
         req_pc[r]    = $urandom;
      end
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic rr);
      req_valid = v;
      rsp_ready = rr;
   endtask

   // One reset cycle, with both requesters asking so that a premature grant
   // would show up. The reset state is checked on the first cycle out of
   // reset.
   task automatic doReset();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(2'b11, 1'b1);
      #1;
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_alu_rst", 32'(alu_rst), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(2'b00, 1'b1);
      #1;
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_alu_enable", 32'(alu_enable), 32'd0);
      checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("rst_rsp_result", rsp_result, 32'd0);
      checkOutput("rst_alu_op1", alu_op1, 32'd0);
      checkOutput("rst_alu_rst_off", 32'(alu_rst), 32'd0);
   endtask

   // One operation from one requester, with cycle-exact timing. 'stall' is
   // the number of RESP cycles with rsp_ready low. During those cycles both
   // requesters ask, and none of them may be offered a grant.
   task automatic runVector(input vec_t v, input int stall);
      logic [NUM_REQ-1:0] e;
      @(negedge clk);
      scramblePayload();
      applyStimulus(2'b00, 1'b1);
      req_valid[v.id] = 1'b1;
      req_instr[v.id] = v.instr;
      req_op1[v.id]   = v.op1;
      req_op2[v.id]   = v.op2;
      req_pc[v.id]    = v.pc;
      e = 2'b01 << v.id;
      #1;
      checkOutput("grant", 32'(req_ready), 32'(e));
      @(negedge clk);
      scramblePayload();
      req_valid = (stall > 0) ? 2'b11 : 2'b00;
      #1;
      checkOutput("issue_enable", 32'(alu_enable), 32'd1);
      checkOutput("issue_instr", 32'(alu_instr), 32'(v.instr));
      checkOutput("issue_op1", alu_op1, v.op1);
      checkOutput("issue_op2", alu_op2, v.op2);
      checkOutput("issue_pc", alu_pc, v.pc);
      checkOutput("issue_ready", 32'(req_ready), 32'd0);
      checkOutput("issue_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("wait_enable", 32'(alu_enable), 32'd0);
      checkOutput("wait_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("wait_op1_hold", alu_op1, v.op1);
      @(negedge clk);
      rsp_ready = (stall == 0);
      if (stall == 0) req_valid = 2'b00;
      #1;
      checkOutput("resp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("resp_id", 32'(rsp_id), v.id);
      checkOutput("resp_result", rsp_result, v.result);
      checkOutput("resp_op1_hold", alu_op1, v.op1);
      for (int s = 1; s <= stall; s++) begin
         @(negedge clk);
         rsp_ready = (s == stall);
         if (s == stall) req_valid = 2'b00;
         #1;
         checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
         checkOutput("stall_id", 32'(rsp_id), v.id);
         checkOutput("stall_result", rsp_result, v.result);
         checkOutput("stall_ready", 32'(req_ready), 32'd0);
         checkOutput("stall_enable", 32'(alu_enable), 32'd0);
      end
      @(negedge clk);
      #1;
      checkOutput("post_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("post_enable", 32'(alu_enable), 32'd0);
   endtask

   initial begin
      int grants [4];
      int gcycle [4];
      int ngrants;
      int expg;
      int phase;
      int ptr;
      int w;
      logic [NUM_REQ-1:0] e;
      instruction_t mInstr;
      register_t    mOp1, mOp2, mPc, mRes;
      int           mId;
      vec_t         hv;

      vecs[0] = '{id: 0, instr: M_ADD,   op1: 32'd5,          op2: 32'd7,      pc: 32'd0,    result: 32'd12};
      vecs[1] = '{id: 1, instr: M_AUIPC, op1: 32'h1000,       op2: 32'd0,      pc: 32'h20,   result: 32'h1020};
      vecs[2] = '{id: 1, instr: M_SUB,   op1: 32'd9,          op2: 32'd4,      pc: 32'd0,    result: 32'd5};
      vecs[3] = '{id: 0, instr: M_XOR,   op1: 32'hF0F0,       op2: 32'h0FF0,   pc: 32'd0,    result: 32'hFF00};
      vecs[4] = '{id: 0, instr: M_SUB,   op1: 32'd0,          op2: 32'd1,      pc: 32'd0,    result: 32'hFFFF_FFFF};
      vecs[5] = '{id: 1, instr: M_ADD,   op1: 32'hFFFF_FFFF,  op2: 32'd1,      pc: 32'h44,   result: 32'd0};

      rst = 1'b0;
      applyStimulus(2'b00, 1'b1);
      scramblePayload();
      doReset();

      for (int i = 0; i < 6; i++) runVector(vecs[i], 0);

      // Response held off for five cycles
      hv = '{id: 0, instr: M_OR, op1: 32'hA0, op2: 32'h0B, pc: 32'd0, result: 32'hAB};
      runVector(hv, 5);

      // Reset asserted while the operation sits in WAIT. It must vanish
      // without a response, and the next operation must behave normally.
      @(negedge clk);
      applyStimulus(2'b01, 1'b1);
      req_instr[0] = M_ADD; req_op1[0] = 32'd3; req_op2[0] = 32'd4; req_pc[0] = 32'd0;
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      checkOutput("abort_issue", 32'(alu_enable), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 2'b11;
      #1;
      checkOutput("abort_alu_rst", 32'(alu_rst), 32'd1);
      checkOutput("abort_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      req_valid = 2'b00;
      #1;
      checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("abort_enable", 32'(alu_enable), 32'd0);
      checkOutput("abort_result", rsp_result, 32'd0);
      checkOutput("abort_op1", alu_op1, 32'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         checkOutput("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end
      runVector(vecs[2], 0);

      // Both requesters ask continuously. Record which one is granted on
      // each of the first four accepts and how far apart those accepts are.
      doReset();
      ngrants = 0;
      for (int c = 0; c < 40 && ngrants < 4; c++) begin
         @(negedge clk);
         applyStimulus(2'b11, 1'b1);
         scramblePayload();
         #1;
         if (req_ready != 2'b00) begin
            checkOutput("arb_onehot", 32'($countones(req_ready)), 32'd1);
            grants[ngrants] = req_ready[1] ? 1 : 0;
            gcycle[ngrants] = c;
            ngrants++;
         end
      end
      checkOutput("arb_count", 32'(ngrants), 32'd4);
      for (int k = 0; k < ngrants; k++) begin
`ifdef ALU_ARB_RR_EN
         expg = k % 2;
`else
         expg = 0;
`endif
         checkOutput("arb_grant", 32'(grants[k]), 32'(expg));
         if (k > 0) checkOutput("arb_spacing", 32'(gcycle[k] - gcycle[k-1]), 32'd4);
      end
      @(negedge clk);
      applyStimulus(2'b00, 1'b1);
      repeat (5) @(negedge clk);

      // Randomized traffic against a transaction-level reference: one
      // operation in flight. The response appears three cycles after the
      // accept and is held until it is taken.
      doReset();
      phase = 0;
      ptr   = 0;
      mId   = 0;
      mInstr = M_ADD; mOp1 = '0; mOp2 = '0; mPc = '0; mRes = '0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         scramblePayload();
         applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
         #1;
         w = (phase == 0) ? pickRef(req_valid, ptr) : -1;
         e = (w >= 0) ? (2'b01 << w) : 2'b00;
         checkOutput("rnd_ready", 32'(req_ready), 32'(e));
         checkOutput("rnd_enable", 32'(alu_enable), 32'(phase == 1));
         checkOutput("rnd_rsp_valid", 32'(rsp_valid), 32'(phase == 3));
         if (phase == 1) begin
            checkOutput("rnd_instr", 32'(alu_instr), 32'(mInstr));
            checkOutput("rnd_op1", alu_op1, mOp1);
            checkOutput("rnd_op2", alu_op2, mOp2);
            checkOutput("rnd_pc", alu_pc, mPc);
         end
         if (phase == 3) begin
            checkOutput("rnd_rsp_id", 32'(rsp_id), 32'(mId));
            checkOutput("rnd_rsp_result", rsp_result, mRes);
         end
         if (w >= 0) begin
            mId    = w;
            mInstr = req_instr[w];
            mOp1   = req_op1[w];
            mOp2   = req_op2[w];
            mPc    = req_pc[w];
            mRes   = aluRef(req_instr[w], req_op1[w], req_op2[w], req_pc[w]);
`ifdef ALU_ARB_RR_EN
            ptr = (w + 1) % NUM_REQ;
`endif
            phase = 1;
         end else if (phase == 1 || phase == 2) begin
            phase = phase + 1;
         end else if (phase == 3 && rsp_ready) begin
            phase = 0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
